sr_bank_arbiter: RTL and testbench

- Controller that shares one bank of W master-slave SR flip-flops (active-low S/R, Q/Qn outputs) between two write requesters.
- Grants requesters round-robin and converts each granted SET/CLR/WRITE operation into legal active-low S_n/R_n pulse vectors.
- Holds each pulse across a full clock period so the master-slave bank captures it, then verifies the result against the bank Q outputs and retries on mismatch.
- Sits between requester logic and the flip-flop bank; the bank is external to this block.

---
 rtl/sr_bank_pkg.sv | 17 +
 rtl/sr_pattern_gen.sv | 43 ++++
 rtl/sr_bank_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sr_bank_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_bank_pkg.sv
// rtl/sr_bank_pkg.sv - shared op and state encodings for the SR bank arbiter
package sr_bank_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_SET   = 2'b01,
        OP_CLR   = 2'b10,
        OP_WRITE = 2'b11
    } op_e;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRIVE = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/sr_pattern_gen.sv
// rtl/sr_pattern_gen.sv - op/mask/data to active-low S/R pulse vectors and readback target
module sr_pattern_gen
    import sr_bank_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [1:0]   op_i,
    input  logic [W-1:0] mask_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] s_n_o,
    output logic [W-1:0] r_n_o,
    output logic [W-1:0] target_o
);

    logic [W-1:0] set_bits;
    logic [W-1:0] clr_bits;

    always_comb begin
        set_bits = '0;
        clr_bits = '0;
        target_o = data_i;
        case (op_i)
            OP_SET: begin
                set_bits = mask_i;
                target_o = '1;
            end
            OP_CLR: begin
                clr_bits = mask_i;
                target_o = '0;
            end
            OP_WRITE: begin
                set_bits = mask_i & data_i;
                clr_bits = mask_i & ~data_i;
            end
            default: ;
        endcase
    end

    // Set wins structurally, so no bit can ever present S_n=R_n=0 to the bank.
    assign s_n_o = ~set_bits;
    assign r_n_o = ~(clr_bits & ~set_bits);

endmodule

// File: rtl/sr_bank_arbiter.sv
// rtl/sr_bank_arbiter.sv - round-robin arbiter driving a master-slave SR bank with readback retry
module sr_bank_arbiter
    import sr_bank_pkg::*;
#(
    parameter int W         = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req,
    input  logic [1:0]   op0,
    input  logic [W-1:0] mask0,
    input  logic [W-1:0] data0,
    input  logic [1:0]   op1,
    input  logic [W-1:0] mask1,
    input  logic [W-1:0] data1,
    output logic [1:0]   ack,
    output logic         err,
    output logic         busy,
    output logic [W-1:0] s_n,
    output logic [W-1:0] r_n,
    input  logic [W-1:0] q
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic [2:0]    state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [1:0]    op_q, op_d;
    logic [W-1:0]  mask_q, mask_d;
    logic [W-1:0]  data_q, data_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [W-1:0]  s_n_q, s_n_d;
    logic [W-1:0]  r_n_q, r_n_d;
    logic [1:0]    ack_q, ack_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic          take;
    logic          cmd_nop;
    logic          match;
    logic [W-1:0]  pat_s_n;
    logic [W-1:0]  pat_r_n;
    logic [W-1:0]  pat_target;

    // Driven from the next-state command so the pattern reaches the pins on the grant edge.
    sr_pattern_gen #(.W(W)) u_pattern (
        .op_i     (op_d),
        .mask_i   (mask_d),
        .data_i   (data_d),
        .s_n_o    (pat_s_n),
        .r_n_o    (pat_r_n),
        .target_o (pat_target)
    );

    assign cmd_nop = (op_q == OP_NOP) || (mask_q == '0);
    assign match   = ((q ^ pat_target) & mask_q) == '0;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        op_d    = op_q;
        mask_d  = mask_q;
        data_d  = data_q;
        retry_d = retry_q;
        err_d   = 1'b0;
        take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    take    = 1'b1;
                    gnt_d   = (req == 2'b11) ? ~last_q : req[1];
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: state_d = cmd_nop ? ST_DONE : ST_HOLD;
            ST_HOLD:  state_d = ST_CHECK;
            ST_CHECK: begin
                if (match) begin
                    state_d = ST_DONE;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + RW'(1);
                    state_d = ST_DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                last_d  = gnt_q;
                retry_d = '0;
                // The served requester still holds req this cycle, so only the other one may chain in.
                if (req[~gnt_q]) begin
                    take    = 1'b1;
                    gnt_d   = ~gnt_q;
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take) begin
            op_d    = gnt_d ? op1   : op0;
            mask_d  = gnt_d ? mask1 : mask0;
            data_d  = gnt_d ? data1 : data0;
            retry_d = '0;
        end
    end

    always_comb begin
        s_n_d  = '1;
        r_n_d  = '1;
        if (state_d == ST_DRIVE || state_d == ST_HOLD) begin
            s_n_d = pat_s_n;
            r_n_d = pat_r_n;
        end
        ack_d  = (state_d == ST_DONE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            op_q    <= 2'b00;
            mask_q  <= '0;
            data_q  <= '0;
            retry_q <= '0;
            s_n_q   <= '1;
            r_n_q   <= '1;
            ack_q   <= 2'b00;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            op_q    <= op_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            retry_q <= retry_d;
            s_n_q   <= s_n_d;
            r_n_q   <= r_n_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign s_n  = s_n_q;
    assign r_n  = r_n_q;
    assign ack  = ack_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// tb/tb_sr_bank_arbiter.sv - randomized self-checking bench with a behavioural master-slave SR bank
module tb_sr_bank_arbiter;
    import sr_bank_pkg::*;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req   = 2'b00;
    logic [1:0]   op0   = 2'b00;
    logic [1:0]   op1   = 2'b00;
    logic [W-1:0] mask0 = '0;
    logic [W-1:0] data0 = '0;
    logic [W-1:0] mask1 = '0;
    logic [W-1:0] data1 = '0;
    logic [1:0]   ack;
    logic         err;
    logic         busy;
    logic [W-1:0] s_n;
    logic [W-1:0] r_n;
    logic [W-1:0] q;
    logic [W-1:0] bank_q;
    logic [W-1:0] stuck     = '0;
    logic [W-1:0] model_raw = '0;
    int           errors    = 0;
    int           checks    = 0;

    always #5 clk = ~clk;

    sr_bank_arbiter #(.W(W), .MAX_RETRY(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .op0   (op0),
        .mask0 (mask0),
        .data0 (data0),
        .op1   (op1),
        .mask1 (mask1),
        .data1 (data1),
        .ack   (ack),
        .err   (err),
        .busy  (busy),
        .s_n   (s_n),
        .r_n   (r_n),
        .q     (q)
    );

    // Master latch transparent while clk high, slave while clk low.
    for (genvar i = 0; i < W; i++) begin : g_ms_ff
        logic m = 1'b0;
        logic s = 1'b0;
        always_latch begin
            if (clk) begin
                if (!s_n[i])      m <= 1'b1;
                else if (!r_n[i]) m <= 1'b0;
            end
        end
        always_latch begin
            if (!clk) s <= m;
        end
        assign bank_q[i] = s;
    end
    assign q = bank_q & ~stuck;

    always @(negedge clk) begin
        checks++;
        if ((~s_n & ~r_n) != '0) begin
            errors++;
            $display("FAIL invariant: s_n=%h r_n=%h, required no bit low in both", s_n, r_n);
        end
        checks++;
        if (ack == 2'b11 || (err && ack == 2'b00)) begin
            errors++;
            $display("FAIL ack_onehot: ack=%b err=%b, required one-hot ack and err only with ack", ack, err);
        end
    end

    function automatic logic [W-1:0] apply_op(input logic [1:0] op, input logic [W-1:0] mask,
                                              input logic [W-1:0] data, input logic [W-1:0] raw);
        case (op)
            2'b01:   return raw | mask;
            2'b10:   return raw & ~mask;
            2'b11:   return (raw & ~mask) | (data & mask);
            default: return raw;
        endcase
    endfunction

    task automatic set_cmd(input int r, input logic [1:0] op, input logic [W-1:0] mask, input logic [W-1:0] data);
        if (r == 0) begin
            op0 = op; mask0 = mask; data0 = data;
        end else begin
            op1 = op; mask1 = mask; data1 = data;
        end
    endtask

    // Raises req[r] at a negedge, observes until ack (40-cycle bound), then one idle cycle.
    task automatic issue(input int r, input logic [1:0] op, input logic [W-1:0] mask, input logic [W-1:0] data,
                         input bit drop_early, output int lat, output logic err_seen, output int pat_cyc,
                         output int drives, output logic [W-1:0] sn_seen, output logic [W-1:0] rn_seen,
                         output int busy_cyc, output logic busy_after);
        bit prev_active;
        prev_active = 1'b0;
        lat = -1; err_seen = 1'b0; pat_cyc = 0; drives = 0; sn_seen = '1; rn_seen = '1; busy_cyc = 0;
        set_cmd(r, op, mask, data);
        req[r] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (s_n != '1 || r_n != '1) begin
                if (pat_cyc == 0) begin
                    sn_seen = s_n;
                    rn_seen = r_n;
                end
                if (!prev_active) drives++;
                pat_cyc++;
                prev_active = 1'b1;
            end else begin
                prev_active = 1'b0;
            end
            if (k == 1) set_cmd(r, 2'($urandom), W'($urandom), W'($urandom));
            if (drop_early && k == 2) req[r] = 1'b0;
            if (ack[r]) begin
                lat = k;
                err_seen = err;
                req[r] = 1'b0;
                break;
            end
        end
        req[r] = 1'b0;
        @(negedge clk);
        busy_after = busy;
    endtask

    task automatic test_reset();
        int acks;
        @(negedge clk); @(negedge clk);
        checks += 5;
        if (s_n !== 8'hFF) begin errors++; $display("FAIL reset_s_n: got %h want ff", s_n); end
        if (r_n !== 8'hFF) begin errors++; $display("FAIL reset_r_n: got %h want ff", r_n); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", ack); end
        if (err !== 1'b0)  begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        rst_n = 1'b1;
        @(negedge clk);
        set_cmd(0, OP_SET, 8'hFF, 8'h00);
        req[0] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_n !== 8'h00) begin errors++; $display("FAIL middrive_s_n: got %h want 00", s_n); end
        #1 rst_n = 1'b0;
        #1;
        checks += 4;
        if (s_n !== 8'hFF) begin errors++; $display("FAIL abort_s_n: got %h want ff", s_n); end
        if (r_n !== 8'hFF) begin errors++; $display("FAIL abort_r_n: got %h want ff", r_n); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (ack !== 2'b00) begin errors++; $display("FAIL abort_ack: got %b want 00", ack); end
        req = 2'b00;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack != 2'b00 || busy) acks++;
        end
        checks++;
        if (acks != 0) begin errors++; $display("FAIL abort_no_ack: got %0d ack/busy cycles want 0", acks); end
    endtask

    task automatic test_write();
        int lat, pc, dr, bc; logic e, ba; logic [W-1:0] sn, rn;
        issue(0, OP_CLR, 8'hFF, 8'h00, 1'b0, lat, e, pc, dr, sn, rn, bc, ba);
        model_raw = apply_op(OP_CLR, 8'hFF, 8'h00, model_raw);
        checks += 2;
        if (q !== 8'h00) begin errors++; $display("FAIL clr_q: got %h want 00", q); end
        if (lat != 4)    begin errors++; $display("FAIL clr_lat: got %0d want 4", lat); end
        issue(0, OP_WRITE, 8'hF0, 8'hA5, 1'b0, lat, e, pc, dr, sn, rn, bc, ba);
        model_raw = apply_op(OP_WRITE, 8'hF0, 8'hA5, model_raw);
        checks += 8;
        if (sn !== 8'h5F) begin errors++; $display("FAIL write_s_n: got %h want 5f", sn); end
        if (rn !== 8'hAF) begin errors++; $display("FAIL write_r_n: got %h want af", rn); end
        if (pc != 2)      begin errors++; $display("FAIL write_pulse_cycles: got %0d want 2", pc); end
        if (q !== 8'hA0)  begin errors++; $display("FAIL write_q: got %h want a0", q); end
        if (lat != 4)     begin errors++; $display("FAIL write_lat: got %0d want 4", lat); end
        if (e !== 1'b0)   begin errors++; $display("FAIL write_err: got %b want 0", e); end
        if (bc != 4)      begin errors++; $display("FAIL write_busy_cycles: got %0d want 4", bc); end
        if (ba !== 1'b0)  begin errors++; $display("FAIL write_busy_after: got %b want 0", ba); end
    endtask

    task automatic test_nop();
        int lat, pc, dr, bc; logic e, ba; logic [W-1:0] sn, rn;
        issue(1, OP_NOP, 8'hFF, 8'hFF, 1'b0, lat, e, pc, dr, sn, rn, bc, ba);
        checks += 3;
        if (pc != 0)          begin errors++; $display("FAIL nop_pulse_cycles: got %0d want 0", pc); end
        if (lat != 2)         begin errors++; $display("FAIL nop_lat: got %0d want 2", lat); end
        if (q !== model_raw)  begin errors++; $display("FAIL nop_q: got %h want %h", q, model_raw); end
        issue(0, OP_SET, 8'h00, 8'hFF, 1'b0, lat, e, pc, dr, sn, rn, bc, ba);
        checks += 3;
        if (pc != 0)          begin errors++; $display("FAIL mask0_pulse_cycles: got %0d want 0", pc); end
        if (lat != 2)         begin errors++; $display("FAIL mask0_lat: got %0d want 2", lat); end
        if (q !== model_raw)  begin errors++; $display("FAIL mask0_q: got %h want %h", q, model_raw); end
    endtask

    task automatic test_stuck();
        int lat, pc, dr, bc; logic e, ba; logic [W-1:0] sn, rn;
        stuck = 8'h08;
        issue(0, OP_SET, 8'h08, 8'h00, 1'b0, lat, e, pc, dr, sn, rn, bc, ba);
        model_raw = apply_op(OP_SET, 8'h08, 8'h00, model_raw);
        checks += 5;
        if (dr != 3)        begin errors++; $display("FAIL stuck_drives: got %0d want 3", dr); end
        if (pc != 6)        begin errors++; $display("FAIL stuck_pulse_cycles: got %0d want 6", pc); end
        if (lat != 10)      begin errors++; $display("FAIL stuck_lat: got %0d want 10", lat); end
        if (e !== 1'b1)     begin errors++; $display("FAIL stuck_err: got %b want 1", e); end
        if (q[3] !== 1'b0)  begin errors++; $display("FAIL stuck_q3: got %b want 0", q[3]); end
        stuck = '0;
    endtask

    task automatic test_back_to_back();
        int a0, a1, gaps; logic q0_a0, q0_a1;
        a0 = -1; a1 = -1; gaps = 0; q0_a0 = 1'bx; q0_a1 = 1'bx;
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_cmd(0, OP_SET, 8'h01, 8'h00);
        set_cmd(1, OP_CLR, 8'h01, 8'h00);
        req = 2'b11;
        for (int k = 1; k <= 30 && a1 < 0; k++) begin
            @(negedge clk);
            if (!busy) gaps++;
            if (ack[0]) begin a0 = k; q0_a0 = q[0]; req[0] = 1'b0; end
            if (ack[1]) begin a1 = k; q0_a1 = q[0]; req[1] = 1'b0; end
        end
        req = 2'b00;
        @(negedge clk);
        model_raw = apply_op(OP_CLR, 8'h01, 8'h00, apply_op(OP_SET, 8'h01, 8'h00, model_raw));
        checks += 5;
        if (a0 != 4)         begin errors++; $display("FAIL b2b_ack0_lat: got %0d want 4", a0); end
        if (a1 != 8)         begin errors++; $display("FAIL b2b_ack1_lat: got %0d want 8", a1); end
        if (q0_a0 !== 1'b1)  begin errors++; $display("FAIL b2b_q0_after_set: got %b want 1", q0_a0); end
        if (q0_a1 !== 1'b0)  begin errors++; $display("FAIL b2b_q0_after_clr: got %b want 0", q0_a1); end
        if (gaps != 0)       begin errors++; $display("FAIL b2b_busy_gaps: got %0d want 0", gaps); end
    endtask

    task automatic test_random();
        int lat, pc, dr, bc, r, exp_lat, exp_pc; logic e, ba, nop, mism;
        logic [1:0] op; logic [W-1:0] sn, rn, mask, data, nxt, exp_sn, exp_rn;
        for (int n = 0; n < 40; n++) begin
            r    = $urandom_range(0, 1);
            op   = 2'($urandom);
            mask = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            data = W'($urandom);
            stuck = ($urandom_range(0, 7) == 0) ? W'(1 << $urandom_range(0, W-1)) : '0;
            nop  = (op == 2'b00) || (mask == '0);
            nxt  = apply_op(op, mask, data, model_raw);
            mism = !nop && ((nxt & stuck & mask) != '0);
            exp_sn  = ~((op == 2'b01) ? mask : (op == 2'b11) ? (mask & data) : '0);
            exp_rn  = ~((op == 2'b10) ? mask : (op == 2'b11) ? (mask & ~data) : '0);
            exp_lat = nop ? 2 : (mism ? 10 : 4);
            exp_pc  = nop ? 0 : (mism ? 6 : 2);
            issue(r, op, mask, data, 1'($urandom), lat, e, pc, dr, sn, rn, bc, ba);
            checks += 8;
            if (lat != exp_lat)        begin errors++; $display("FAIL rnd%0d_lat: got %0d want %0d", n, lat, exp_lat); end
            if (e !== mism)            begin errors++; $display("FAIL rnd%0d_err: got %b want %b", n, e, mism); end
            if (pc != exp_pc)          begin errors++; $display("FAIL rnd%0d_pulse_cycles: got %0d want %0d", n, pc, exp_pc); end
            if (sn !== exp_sn)         begin errors++; $display("FAIL rnd%0d_s_n: got %h want %h", n, sn, exp_sn); end
            if (rn !== exp_rn)         begin errors++; $display("FAIL rnd%0d_r_n: got %h want %h", n, rn, exp_rn); end
            if (q !== (nxt & ~stuck))  begin errors++; $display("FAIL rnd%0d_q: got %h want %h", n, q, nxt & ~stuck); end
            if (bc != exp_lat)         begin errors++; $display("FAIL rnd%0d_busy_cycles: got %0d want %0d", n, bc, exp_lat); end
            if (ba !== 1'b0)           begin errors++; $display("FAIL rnd%0d_busy_after: got %b want 0", n, ba); end
            model_raw = nxt;
            stuck = '0;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_nop();
        test_stuck();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
